pulpino_pad_frame: RTL and testbench
====================================

# pulpino_pad_frame

Chip-level pad frame between the PULPino core and the package pins. It unpacks the 14-bit input pin bus `INP` into named core-side signals and packs core outputs into the 11-bit output pin bus `UTP`. It conditions the chip reset and fetch-enable pins into the `clk` domain and holds all output pins at safe idle levels while reset is active. It sits directly under the chip top, with the core instance beside it.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flop depth of the reset and fetch-enable synchronizers; legal range 2–4.

Ports:
- `clk`  in  1  core clock from its pad; the only clock used by this block.
- `rst`  in  1  asynchronous, active-high reset (power-on reset cell). One clock; reset is asynchronous and active-high.
- `spi_clk`  in  1  SPI slave clock pad; buffered straight to `spi_clk_o`.
- `jtag_clk`  in  1  JTAG TCK pad; buffered straight to `tck_o`.
- `INP`  in  14  input pins: [13] tdi, [12] tms, [11] trst_n, [10] uart_dsr, [9] uart_cts, [8] uart_rx, [7:4] spi_sdi3..0, [3] spi_cs_n, [2] fetch_enable, [1] unused, [0] rst_n.
- `UTP`  out  11  output pins: [10] tdo, [9] gpio8 (end-of-test flag), [8] uart_dtr, [7] uart_rts, [6] uart_tx, [5:2] spi_sdo3..0, [1:0] spi_mode.
- Core-side outputs (1 bit unless noted): `spi_clk_o`, `tck_o`, `core_rst_n_o`, `fetch_enable_o`, `tdi_o`, `tms_o`, `trst_n_o`, `uart_dsr_o`, `uart_cts_o`, `uart_rx_o`, `spi_sdi_o`[4], `spi_cs_n_o`.
- Core-side inputs (1 bit unless noted): `tdo_i`, `gpio8_i`, `uart_dtr_i`, `uart_rts_i`, `uart_tx_i`, `spi_sdo_i`[4], `spi_mode_i`[2].

## Operation
- Input pass-through is combinational, with no flops, for every `INP` bit except bits 0, 1 and 2.
- `INP[1]` is ignored.
- **Reset synchronizer.** `core_rst_n_o` is driven by a `SYNC_STAGES`-deep chain.
  - Clear condition: `rst` = 1 or `INP[0]` = 0, applied asynchronously.
  - Shift input: constant 1.
  - Result: assertion is asynchronous; deassertion is synchronous to `clk`.
- **Fetch-enable synchronizer.** `fetch_enable_o` is `INP[2]` passed through a `SYNC_STAGES`-deep chain.
  - Asynchronously cleared by `rst` = 1 or by `core_rst_n_o` = 0.
- **Output pins, normal operation.** `UTP` carries the core outputs combinationally in the bit order listed above.
- **Output pins, safe state.** Whenever `core_rst_n_o` = 0, `UTP` is forced to 11'b001_1100_0000:
  - uart_tx, uart_rts and uart_dtr are held at 1 (idle/deasserted).
  - All other bits are held at 0.
- No output ever carries X after `rst` has been asserted.

## Timing
- Reset values (with `rst` = 1):
  - `core_rst_n_o` = 0 and `fetch_enable_o` = 0.
  - `UTP` = 11'h1C0.
  - Combinational pass-through outputs follow their pins.
- Reset release: with `rst` = 0 and `INP[0]` = 1, `core_rst_n_o` rises on the `SYNC_STAGES`-th rising `clk` edge. With the default of 2, that is the 2nd edge.
- `fetch_enable_o` follows `INP[2]` with a latency of exactly `SYNC_STAGES` rising edges, in both directions.
- If `INP[2]` is already 1 at reset release, `fetch_enable_o` rises `SYNC_STAGES` edges after `core_rst_n_o` rises.
- Reset mid-operation:
  - `rst` = 1 or `INP[0]` = 0 drops `core_rst_n_o` and `fetch_enable_o` within the same delta, with no clock required.
  - `UTP` switches to the safe value in the same delta.
- A glitch on `INP[0]` shorter than one `clk` period still fully resets the core and restarts the release count.
- `spi_clk`/`spi_clk_o` and `jtag_clk`/`tck_o` are pure buffers with no added sequential delay.

## Structure
- Package `pulpino_pads_pkg` holds:
  - Localparams for every `INP`/`UTP` bit index (e.g. `INP_RST_N` = 0, `INP_FETCH_EN` = 2, `UTP_GPIO8` = 9, `UTP_TDO` = 10).
  - `INP_W` = 14, `UTP_W` = 11.
  - `UTP_SAFE` = 11'h1C0.
- One sub-module, `pad_sync`: an N-stage synchronizer with parameters `STAGES` and `RST_VAL` and an asynchronous clear. It is instantiated twice: once for reset, once for fetch enable.

## Test plan
- Hold `rst` = 1 with random `INP` → `core_rst_n_o` = 0, `fetch_enable_o` = 0, `UTP` = 11'h1C0, `tdi_o` equals `INP[13]`.
- Release `rst`, set `INP[0]` = 1 at time t → `core_rst_n_o` = 0 after the 1st `clk` edge and = 1 after the 2nd; `UTP` then equals the core outputs (drive `uart_tx_i` = 0 → `UTP[6]` = 0).
- Set `INP[2]` = 1 after release → `fetch_enable_o` = 1 exactly 2 edges later; drop `INP[2]` → `fetch_enable_o` = 0 exactly 2 edges later.
- Pulse `INP[0]` = 0 for 10 ns in the middle of a clock period, with `clk` = 25 MHz → `core_rst_n_o` and `fetch_enable_o` fall immediately, `UTP` = 11'h1C0, then recovery after 2 edges.
- Walk a single 1 through core outputs {`spi_mode_i`, `spi_sdo_i`, `uart_*_i`, `gpio8_i`, `tdo_i`} → the matching `UTP` bit toggles; toggle `INP[1]` → no output changes.

Source files
------------

// File: rtl/pulpino_pads_pkg.sv
// Pin map and helpers for the PULPino pad frame.
// Bit positions of every input/output pin, the reset-time safe output
// pattern, and pack/unpack helpers between pin buses and named fields.
package pulpino_pads_pkg;

    // Bus widths
    localparam int INP_W = 14;
    localparam int UTP_W = 11;

    // Synchronizer depth limits
    localparam int SYNC_MIN = 2;
    localparam int SYNC_MAX = 4;

    // Input pin bit positions
    localparam int INP_RST_N      = 0;
    localparam int INP_UNUSED     = 1;
    localparam int INP_FETCH_EN   = 2;
    localparam int INP_SPI_CS_N   = 3;
    localparam int INP_SPI_SDI_LO = 4;
    localparam int INP_SPI_SDI_HI = 7;
    localparam int INP_UART_RX    = 8;
    localparam int INP_UART_CTS   = 9;
    localparam int INP_UART_DSR   = 10;
    localparam int INP_TRST_N     = 11;
    localparam int INP_TMS        = 12;
    localparam int INP_TDI        = 13;

    // Output pin bit positions
    localparam int UTP_SPI_MODE_LO = 0;
    localparam int UTP_SPI_MODE_HI = 1;
    localparam int UTP_SPI_SDO_LO  = 2;
    localparam int UTP_SPI_SDO_HI  = 5;
    localparam int UTP_UART_TX     = 6;
    localparam int UTP_UART_RTS    = 7;
    localparam int UTP_UART_DTR    = 8;
    localparam int UTP_GPIO8       = 9;
    localparam int UTP_TDO         = 10;

    // Output pattern while the core is in reset: UART tx/rts/dtr idle high,
    // everything else driven low.
    localparam logic [UTP_W-1:0] UTP_SAFE = 11'h1C0;

    // Core-side signals that leave the chip
    typedef struct packed {
        logic       tdo;
        logic       gpio8;
        logic       uart_dtr;
        logic       uart_rts;
        logic       uart_tx;
        logic [3:0] spi_sdo;
        logic [1:0] spi_mode;
    } core_out_t;

    // Pin-side signals that pass straight through to the core
    typedef struct packed {
        logic       tdi;
        logic       tms;
        logic       trst_n;
        logic       uart_dsr;
        logic       uart_cts;
        logic       uart_rx;
        logic [3:0] spi_sdi;
        logic       spi_cs_n;
    } pin_in_t;

    // Place each core output at its output pin position.
    function automatic logic [UTP_W-1:0] pack_utp(input core_out_t c);
        logic [UTP_W-1:0] u;
        u                                  = '0;
        u[UTP_SPI_MODE_HI:UTP_SPI_MODE_LO] = c.spi_mode;
        u[UTP_SPI_SDO_HI:UTP_SPI_SDO_LO]   = c.spi_sdo;
        u[UTP_UART_TX]                     = c.uart_tx;
        u[UTP_UART_RTS]                    = c.uart_rts;
        u[UTP_UART_DTR]                    = c.uart_dtr;
        u[UTP_GPIO8]                       = c.gpio8;
        u[UTP_TDO]                         = c.tdo;
        return u;
    endfunction

    // Pull the pass-through fields out of the input pin bus.
    function automatic pin_in_t unpack_inp(input logic [INP_W-1:0] p);
        pin_in_t s;
        s.tdi      = p[INP_TDI];
        s.tms      = p[INP_TMS];
        s.trst_n   = p[INP_TRST_N];
        s.uart_dsr = p[INP_UART_DSR];
        s.uart_cts = p[INP_UART_CTS];
        s.uart_rx  = p[INP_UART_RX];
        s.spi_sdi  = p[INP_SPI_SDI_HI:INP_SPI_SDI_LO];
        s.spi_cs_n = p[INP_SPI_CS_N];
        return s;
    endfunction

endpackage

// File: rtl/pad_sync.sv
// N-stage synchronizer with an asynchronous clear.
// The clear forces every stage to RST_VAL immediately; once clear drops, d
// ripples through STAGES flops, so q follows d with STAGES edges of latency.
module pad_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift d towards q each clock; clear all stages asynchronously.
    // NOTE: non-blocking assignment makes every stage capture its
    // predecessor's pre-edge value, which is what forms a real chain.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            chain <= {STAGES{RST_VAL}};
        end else if (STAGES == 1) begin
            chain <= STAGES'(d);
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pulpino_pad_frame.sv
// Chip pad frame for PULPino.
// Unpacks the input pin bus into named core signals, conditions the chip
// reset and fetch-enable pins into the clk domain, and packs core outputs onto
// the output pin bus, holding the pins at safe idle levels while the core is
// in reset.
module pulpino_pad_frame
    import pulpino_pads_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spi_clk,
    input  logic             jtag_clk,
    input  logic [INP_W-1:0] INP,
    output logic [UTP_W-1:0] UTP,

    // core-side outputs
    output logic             spi_clk_o,
    output logic             tck_o,
    output logic             core_rst_n_o,
    output logic             fetch_enable_o,
    output logic             tdi_o,
    output logic             tms_o,
    output logic             trst_n_o,
    output logic             uart_dsr_o,
    output logic             uart_cts_o,
    output logic             uart_rx_o,
    output logic [3:0]       spi_sdi_o,
    output logic             spi_cs_n_o,

    // core-side inputs
    input  logic             tdo_i,
    input  logic             gpio8_i,
    input  logic             uart_dtr_i,
    input  logic             uart_rts_i,
    input  logic             uart_tx_i,
    input  logic [3:0]       spi_sdo_i,
    input  logic [1:0]       spi_mode_i
);

    pin_in_t          pins;
    core_out_t        core_out;
    logic             rst_sync_clr;
    logic             fe_sync_clr;
    logic [UTP_W-1:0] utp_d;
    logic             unused_pin;

    // Clock pads are pure buffers: no gating, no flops.
    assign spi_clk_o = spi_clk;
    assign tck_o     = jtag_clk;

    // Pass-through pins
    assign pins       = unpack_inp(INP);
    assign tdi_o      = pins.tdi;
    assign tms_o      = pins.tms;
    assign trst_n_o   = pins.trst_n;
    assign uart_dsr_o = pins.uart_dsr;
    assign uart_cts_o = pins.uart_cts;
    assign uart_rx_o  = pins.uart_rx;
    assign spi_sdi_o  = pins.spi_sdi;
    assign spi_cs_n_o = pins.spi_cs_n;

    // INP[1] is not bonded to anything in the core.
    assign unused_pin = INP[INP_UNUSED];

    // Either the power-on reset or the external reset pin clears the core
    // reset chain at once; a pulse of any width restarts the release count.
    assign rst_sync_clr = rst | ~INP[INP_RST_N];

    pad_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_rst_sync (
        .clk (clk),
        .clr (rst_sync_clr),
        .d   (1'b1),
        .q   (core_rst_n_o)
    );

    // Fetch enable is held low for as long as the core is in reset, so it
    // can only start counting once core_rst_n_o has been released.
    assign fe_sync_clr = rst | ~core_rst_n_o;

    pad_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_fe_sync (
        .clk (clk),
        .clr (fe_sync_clr),
        .d   (INP[INP_FETCH_EN]),
        .q   (fetch_enable_o)
    );

    // Gather the core outputs into pin order.
    assign core_out = '{
        tdo:      tdo_i,
        gpio8:    gpio8_i,
        uart_dtr: uart_dtr_i,
        uart_rts: uart_rts_i,
        uart_tx:  uart_tx_i,
        spi_sdo:  spi_sdo_i,
        spi_mode: spi_mode_i
    };

    // Drive the output pins from the core, or the safe pattern during reset.
    // NOTE: the safe value is assigned first so every path writes utp_d and
    // no latch is inferred.
    always_comb begin
        utp_d = UTP_SAFE;
        if (core_rst_n_o) begin
            utp_d = pack_utp(core_out);
        end
    end

    assign UTP = utp_d;

endmodule

// File: tb/tb_pulpino_pad_frame.sv
// Directed bench for pulpino_pad_frame with a scoreboard of expected values.
module tb_pulpino_pad_frame;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_clk;
    logic        jtag_clk;
    logic [13:0] INP;
    logic [10:0] UTP;
    logic        spi_clk_o, tck_o, core_rst_n_o, fetch_enable_o;
    logic        tdi_o, tms_o, trst_n_o, uart_dsr_o, uart_cts_o, uart_rx_o;
    logic [3:0]  spi_sdi_o;
    logic        spi_cs_n_o;
    logic        tdo_i, gpio8_i, uart_dtr_i, uart_rts_i, uart_tx_i;
    logic [3:0]  spi_sdo_i;
    logic [1:0]  spi_mode_i;

    logic [13:0] inp_v;
    logic [10:0] core_v;

    typedef struct {
        string       tag;
        logic [31:0] v;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    pulpino_pad_frame dut (
        .clk            (clk),
        .rst            (rst),
        .spi_clk        (spi_clk),
        .jtag_clk       (jtag_clk),
        .INP            (INP),
        .UTP            (UTP),
        .spi_clk_o      (spi_clk_o),
        .tck_o          (tck_o),
        .core_rst_n_o   (core_rst_n_o),
        .fetch_enable_o (fetch_enable_o),
        .tdi_o          (tdi_o),
        .tms_o          (tms_o),
        .trst_n_o       (trst_n_o),
        .uart_dsr_o     (uart_dsr_o),
        .uart_cts_o     (uart_cts_o),
        .uart_rx_o      (uart_rx_o),
        .spi_sdi_o      (spi_sdi_o),
        .spi_cs_n_o     (spi_cs_n_o),
        .tdo_i          (tdo_i),
        .gpio8_i        (gpio8_i),
        .uart_dtr_i     (uart_dtr_i),
        .uart_rts_i     (uart_rts_i),
        .uart_tx_i      (uart_tx_i),
        .spi_sdo_i      (spi_sdo_i),
        .spi_mode_i     (spi_mode_i)
    );

    // 25 MHz clock
    always #20 clk = ~clk;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty: got %0h want nothing", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.v) else begin
                bad++;
                $error("FAIL %s: got %0h want %0h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit order of the output pin bus, from tdo down to spi_mode.
    task automatic set_core(input logic [10:0] v);
        {tdo_i, gpio8_i, uart_dtr_i, uart_rts_i, uart_tx_i, spi_sdo_i, spi_mode_i} = v;
    endtask

    function automatic logic [10:0] pass_obs();
        return {tdi_o, tms_o, trst_n_o, uart_dsr_o, uart_cts_o, uart_rx_o,
                spi_sdi_o, spi_cs_n_o};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset state with random pins
        rst      = 1'b1;
        spi_clk  = 1'b0;
        jtag_clk = 1'b0;
        inp_v    = 14'($urandom);
        INP      = inp_v;
        core_v   = 11'($urandom);
        set_core(core_v);
        #5;
        push("rst_core_rst_n", 0);      check(core_rst_n_o);
        push("rst_fetch_en", 0);        check(fetch_enable_o);
        push("rst_utp", 11'h1C0);       check(UTP);
        push("rst_tdi", inp_v[13]);     check(tdi_o);
        push("rst_pass", inp_v[13:3]);  check(pass_obs());

        // ---- clock buffers
        spi_clk = 1'b1; jtag_clk = 1'b1; #1;
        push("spi_clk_hi", 1); check(spi_clk_o);
        push("tck_hi", 1);     check(tck_o);
        spi_clk = 1'b0; jtag_clk = 1'b0; #1;
        push("spi_clk_lo", 0); check(spi_clk_o);
        push("tck_lo", 0);     check(tck_o);

        // ---- reset release
        inp_v[0] = 1'b1;
        inp_v[2] = 1'b0;
        INP      = inp_v;
        core_v   = 11'h7FF;
        set_core(core_v);
        @(negedge clk);
        rst = 1'b0;
        push("rel_edge1", 0);
        push("rel_edge2", 1);
        tick(); check(core_rst_n_o);
        tick(); check(core_rst_n_o);
        push("norm_utp", core_v); check(UTP);
        core_v[6] = 1'b0;
        set_core(core_v);
        #1;
        push("utp_tx0", 0);          check(UTP[6]);
        push("utp_tx0_all", 11'h7BF); check(UTP);

        // ---- fetch enable latency, both directions
        inp_v[2] = 1'b1; INP = inp_v;
        push("fe_rise_e1", 0);
        push("fe_rise_e2", 1);
        tick(); check(fetch_enable_o);
        tick(); check(fetch_enable_o);
        inp_v[2] = 1'b0; INP = inp_v;
        push("fe_fall_e1", 1);
        push("fe_fall_e2", 0);
        tick(); check(fetch_enable_o);
        tick(); check(fetch_enable_o);

        // ---- 10 ns glitch on the reset pin mid-period
        inp_v[2] = 1'b1; INP = inp_v;
        tick(); tick();
        push("fe_pre_glitch", 1); check(fetch_enable_o);
        @(posedge clk);
        #15;
        inp_v[0] = 1'b0; INP = inp_v;
        #1;
        push("glitch_core", 0);      check(core_rst_n_o);
        push("glitch_fe", 0);        check(fetch_enable_o);
        push("glitch_utp", 11'h1C0); check(UTP);
        #9;
        inp_v[0] = 1'b1; INP = inp_v;
        push("glitch_rec_e1", 0);
        push("glitch_rec_e2", 1);
        push("glitch_fe_e2", 0);
        push("glitch_fe_e3", 0);
        push("glitch_fe_e4", 1);
        push("glitch_rec_utp", 11'h7BF);
        tick(); check(core_rst_n_o);
        tick(); check(core_rst_n_o); check(fetch_enable_o);
        tick(); check(fetch_enable_o);
        tick(); check(fetch_enable_o);
        check(UTP);

        // ---- rst mid-operation with fetch enable pin already high
        #5;
        rst = 1'b1;
        #1;
        push("midrst_core", 0);      check(core_rst_n_o);
        push("midrst_fe", 0);        check(fetch_enable_o);
        push("midrst_utp", 11'h1C0); check(UTP);
        @(negedge clk);
        rst = 1'b0;
        push("midrel_core_e1", 0);
        push("midrel_core_e2", 1);
        push("midrel_fe_e2", 0);
        push("midrel_fe_e3", 0);
        push("midrel_fe_e4", 1);
        tick(); check(core_rst_n_o);
        tick(); check(core_rst_n_o); check(fetch_enable_o);
        tick(); check(fetch_enable_o);
        tick(); check(fetch_enable_o);

        // ---- walking one through core outputs
        for (int i = 0; i < 11; i++) begin
            core_v = 11'(1) << i;
            set_core(core_v);
            #1;
            push($sformatf("walk_%0d", i), core_v);
            check(UTP);
        end

        // ---- random pass-through patterns
        for (int k = 0; k < 4; k++) begin
            inp_v    = 14'($urandom);
            inp_v[0] = 1'b1;
            inp_v[2] = 1'b1;
            INP      = inp_v;
            #1;
            push($sformatf("pass_%0d", k), inp_v[13:3]);
            check(pass_obs());
        end

        // ---- INP[1] has no effect
        inp_v[1] = ~inp_v[1];
        INP      = inp_v;
        #1;
        push("unused_core", 1);           check(core_rst_n_o);
        push("unused_fe", 1);             check(fetch_enable_o);
        push("unused_utp", core_v);       check(UTP);
        push("unused_pass", inp_v[13:3]); check(pass_obs());
        tick(); tick();
        push("unused_core_later", 1);     check(core_rst_n_o);
        push("unused_fe_later", 1);       check(fetch_enable_o);

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_leftover: got %0d want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
